// File: rtl/term_pkg.sv
// Shared types and byte-class helpers for the terminal input path.
package term_pkg;

   typedef enum logic [1:0] {
      PRINT = 2'd0,
      EXEC  = 2'd1,
      ESC   = 2'd2,
      CSI   = 2'd3
   } csi_kind_t;

   typedef enum logic [2:0] {
      GROUND,
      ESCAPE,
      ESC_INTER,
      CSI_ENTRY,
      CSI_PARAM,
      CSI_INTER,
      CSI_IGNORE
   } csi_state_t;

   localparam logic [7:0] ESC_B   = 8'h1B;
   localparam logic [7:0] CAN_B   = 8'h18;
   localparam logic [7:0] SUB_B   = 8'h1A;
   localparam logic [7:0] DEL_B   = 8'h7F;
   localparam logic [7:0] CSI_B   = 8'h5B;
   localparam logic [7:0] SEP_B   = 8'h3B;

   function automatic logic is_digit(input logic [7:0] b);
      return (b >= 8'h30) && (b <= 8'h39);
   endfunction

   function automatic logic is_final(input logic [7:0] b);
      return (b >= 8'h40) && (b <= 8'h7E);
   endfunction

   function automatic logic is_inter(input logic [7:0] b);
      return (b >= 8'h20) && (b <= 8'h2F);
   endfunction

   function automatic logic is_private(input logic [7:0] b);
      return (b >= 8'h3C) && (b <= 8'h3F);
   endfunction

endpackage

// File: rtl/csi_param_accum.sv
// Saturating decimal accumulator plus CSI parameter slot array.
// Outputs are a live view: committed slots with the in-progress field overlaid at the current index.
module csi_param_accum #(
   parameter int MAX_PARAMS = 16,
   parameter int PARAM_W    = 16,
   parameter int CW         = $clog2(MAX_PARAMS + 1)
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          clr,
   input  logic                          digit_en,
   input  logic [3:0]                    digit,
   input  logic                          sep,
   input  logic                          commit,
   output logic [CW-1:0]                 param_count,
   output logic [MAX_PARAMS*PARAM_W-1:0] params,
   output logic                          overflow
);

   localparam logic [CW-1:0] LAST = CW'(MAX_PARAMS - 1);
   localparam logic [CW-1:0] FULL = CW'(MAX_PARAMS);

   logic [PARAM_W-1:0] acc;
   logic [PARAM_W-1:0] acc_n;
   logic [PARAM_W+3:0] acc_x10;
   logic [CW-1:0]      idx;
   logic               seen;
   logic               in_range;
   logic [PARAM_W-1:0] slots [MAX_PARAMS];

   assign in_range = (idx < FULL);

   always_comb begin
      acc_x10 = ({4'b0, acc} << 3) + ({4'b0, acc} << 1) + {{PARAM_W{1'b0}}, digit};
      acc_n   = (acc_x10 > {4'b0, {PARAM_W{1'b1}}}) ? {PARAM_W{1'b1}} : acc_x10[PARAM_W-1:0];
   end

   always_ff @(posedge clk) begin
      if (!rst || clr) begin
         acc      <= '0;
         idx      <= '0;
         seen     <= 1'b0;
         overflow <= 1'b0;
         for (int i = 0; i < MAX_PARAMS; i++) slots[i] <= '0;
      end else begin
         if (digit_en) begin
            acc  <= acc_n;
            seen <= 1'b1;
         end
         if (sep) begin
            seen <= 1'b1;
            acc  <= '0;
            if (in_range) begin
               slots[idx] <= acc;
               idx        <= idx + 1'b1;
            end
            // a separator at the last slot opens a field with nowhere to go
            if (idx >= LAST) overflow <= 1'b1;
         end
         if (commit && seen && in_range) slots[idx] <= acc;
      end
   end

   always_comb begin
      params = '0;
      for (int i = 0; i < MAX_PARAMS; i++) begin
         params[i*PARAM_W +: PARAM_W] = (seen && idx == CW'(i)) ? acc : slots[i];
      end
      if (!seen)         param_count = '0;
      else if (in_range) param_count = idx + 1'b1;
      else               param_count = FULL;
   end

endmodule

// File: rtl/csi_sequence_parser.sv
// ECMA-48 byte classifier emitting one PRINT/EXEC/ESC/CSI record per complete item.
// Record appears the cycle after its last byte; single output register, in_ready = !out_valid.
module csi_sequence_parser
   import term_pkg::*;
#(
   parameter int MAX_PARAMS = 16,
   parameter int PARAM_W    = 16,
   parameter int CW         = $clog2(MAX_PARAMS + 1)
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [7:0]                    in_data,
   input  logic                          in_valid,
   output logic                          in_ready,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic [1:0]                    out_kind,
   output logic [7:0]                    out_final,
   output logic [7:0]                    out_private,
   output logic [7:0]                    out_inter,
   output logic [CW-1:0]                 out_param_count,
   output logic [MAX_PARAMS*PARAM_W-1:0] out_params,
   output logic                          out_overflow
);

   csi_state_t state, state_n;
   csi_kind_t  emit_kind;
   logic       accept, emit, clr_rec, digit_en, sep, commit, set_priv, set_inter;
   logic [7:0] priv_q, inter_q;

   logic [CW-1:0]                 acc_count;
   logic [MAX_PARAMS*PARAM_W-1:0] acc_params;
   logic                          acc_ovf;

   assign in_ready = !out_valid;
   assign accept   = in_valid && in_ready;

   csi_param_accum #(
      .MAX_PARAMS(MAX_PARAMS),
      .PARAM_W   (PARAM_W),
      .CW        (CW)
   ) u_accum (
      .clk        (clk),
      .rst        (rst),
      .clr        (clr_rec),
      .digit_en   (digit_en),
      .digit      (in_data[3:0]),
      .sep        (sep),
      .commit     (commit),
      .param_count(acc_count),
      .params     (acc_params),
      .overflow   (acc_ovf)
   );

   always_ff @(posedge clk) begin
      if (!rst) state <= GROUND;
      else      state <= state_n;
   end

   always_comb begin
      state_n   = state;
      emit      = 1'b0;
      emit_kind = PRINT;
      clr_rec   = 1'b0;
      digit_en  = 1'b0;
      sep       = 1'b0;
      commit    = 1'b0;
      set_priv  = 1'b0;
      set_inter = 1'b0;
      if (accept) begin
         if (in_data == ESC_B) begin
            clr_rec = 1'b1;
            state_n = ESCAPE;
         end else if (in_data == CAN_B || in_data == SUB_B) begin
            state_n = GROUND;
         end else if (in_data < 8'h20) begin
            emit      = 1'b1;
            emit_kind = EXEC;
         end else if (!(in_data == DEL_B && state != GROUND)) begin
            case (state)
               GROUND: begin
                  emit      = 1'b1;
                  emit_kind = PRINT;
               end
               ESCAPE: begin
                  if (in_data == CSI_B) begin
                     clr_rec = 1'b1;
                     state_n = CSI_ENTRY;
                  end else if (is_inter(in_data)) begin
                     set_inter = 1'b1;
                     state_n   = ESC_INTER;
                  end else if (in_data >= 8'h30 && in_data <= 8'h7E) begin
                     emit      = 1'b1;
                     emit_kind = ESC;
                     state_n   = GROUND;
                  end
               end
               ESC_INTER: begin
                  if (in_data >= 8'h30 && in_data <= 8'h7E) begin
                     emit      = 1'b1;
                     emit_kind = ESC;
                     state_n   = GROUND;
                  end
               end
               CSI_ENTRY, CSI_PARAM: begin
                  if (state == CSI_ENTRY && is_private(in_data)) begin
                     set_priv = 1'b1;
                     state_n  = CSI_PARAM;
                  end else if (is_digit(in_data)) begin
                     digit_en = 1'b1;
                     state_n  = CSI_PARAM;
                  end else if (in_data == SEP_B) begin
                     sep     = 1'b1;
                     state_n = CSI_PARAM;
                  end else if (is_inter(in_data)) begin
                     set_inter = 1'b1;
                     state_n   = CSI_INTER;
                  end else if (is_final(in_data)) begin
                     commit    = 1'b1;
                     emit      = 1'b1;
                     emit_kind = CSI;
                     state_n   = GROUND;
                  end else if (in_data >= 8'h3A && in_data <= 8'h3F) begin
                     // sub-parameters and late private markers are not supported
                     state_n = CSI_IGNORE;
                  end
               end
               CSI_INTER: begin
                  if (is_final(in_data)) begin
                     emit      = 1'b1;
                     emit_kind = CSI;
                     state_n   = GROUND;
                  end else if (in_data >= 8'h20 && in_data <= 8'h3F) begin
                     state_n = CSI_IGNORE;
                  end
               end
               CSI_IGNORE: begin
                  if (is_final(in_data)) state_n = GROUND;
               end
               default: state_n = GROUND;
            endcase
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         priv_q          <= '0;
         inter_q         <= '0;
         out_valid       <= 1'b0;
         out_kind        <= '0;
         out_final       <= '0;
         out_private     <= '0;
         out_inter       <= '0;
         out_param_count <= '0;
         out_params      <= '0;
         out_overflow    <= 1'b0;
      end else begin
         if (clr_rec) begin
            priv_q  <= '0;
            inter_q <= '0;
         end else begin
            if (set_priv)  priv_q  <= in_data;
            if (set_inter) inter_q <= in_data;
         end

         if (emit) begin
            out_valid       <= 1'b1;
            out_kind        <= emit_kind;
            out_final       <= in_data;
            out_private     <= (emit_kind == CSI) ? priv_q : 8'h00;
            out_inter       <= (emit_kind == CSI || emit_kind == ESC) ? inter_q : 8'h00;
            out_param_count <= (emit_kind == CSI) ? acc_count : '0;
            out_params      <= (emit_kind == CSI) ? acc_params : '0;
            out_overflow    <= (emit_kind == CSI) ? acc_ovf : 1'b0;
         end else if (out_ready) begin
            out_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_csi_sequence_parser.sv
// Directed-vector bench for csi_sequence_parser with hand-computed expected records.
module tb_csi_sequence_parser;

   localparam int MP = 16;
   localparam int PW = 16;
   localparam int CW = 5;

   typedef struct packed {
      logic [1:0]       kind;
      logic [7:0]       fin;
      logic [7:0]       priv;
      logic [7:0]       inter;
      logic [CW-1:0]    cnt;
      logic             ovf;
      logic [MP*PW-1:0] prm;
   } rec_t;

   logic             clk = 1'b0;
   logic             rst = 1'b0;
   logic [7:0]       in_data = 8'h00;
   logic             in_valid = 1'b0;
   logic             in_ready;
   logic             out_valid;
   logic             out_ready = 1'b1;
   logic [1:0]       out_kind;
   logic [7:0]       out_final;
   logic [7:0]       out_private;
   logic [7:0]       out_inter;
   logic [CW-1:0]    out_param_count;
   logic [MP*PW-1:0] out_params;
   logic             out_overflow;

   int   n_cmp  = 0;
   int   n_fail = 0;
   rec_t q[$];

   csi_sequence_parser #(.MAX_PARAMS(MP), .PARAM_W(PW), .CW(CW)) dut (
      .clk            (clk),
      .rst            (rst),
      .in_data        (in_data),
      .in_valid       (in_valid),
      .in_ready       (in_ready),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .out_kind       (out_kind),
      .out_final      (out_final),
      .out_private    (out_private),
      .out_inter      (out_inter),
      .out_param_count(out_param_count),
      .out_params     (out_params),
      .out_overflow   (out_overflow)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (rst && out_valid === 1'b1 && out_ready) begin
         q.push_back('{kind: out_kind, fin: out_final, priv: out_private, inter: out_inter,
                       cnt: out_param_count, ovf: out_overflow, prm: out_params});
      end
   end

   function automatic rec_t mk(input logic [1:0] kind, input logic [7:0] fin, input logic [7:0] priv,
                               input logic [7:0] inter, input int cnt, input logic ovf);
      rec_t r;
      r.kind = kind; r.fin = fin; r.priv = priv; r.inter = inter;
      r.cnt = CW'(cnt); r.ovf = ovf; r.prm = '0;
      return r;
   endfunction

   function automatic string fmt(input rec_t r);
      return $sformatf("kind=%0d final=%h priv=%h inter=%h cnt=%0d ovf=%b params=%h",
                       r.kind, r.fin, r.priv, r.inter, r.cnt, r.ovf, r.prm);
   endfunction

   task automatic send(input logic [7:0] b);
      int n = 0;
      while (in_ready !== 1'b1 && n < 50) begin
         @(posedge clk); #1; n++;
      end
      if (n >= 50) begin
         n_fail++;
         $display("FAIL send_timeout: in_ready=%b required 1", in_ready);
      end
      in_data  = b;
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic send_str(input string s);
      for (int i = 0; i < s.len(); i++) send(s[i]);
   endtask

   task automatic pop_rec(output rec_t r, output bit ok);
      int n = 0;
      while (q.size() == 0 && n < 50) begin
         @(posedge clk); #1; n++;
      end
      ok = (q.size() != 0);
      r  = ok ? q.pop_front() : '0;
   endtask

   task automatic test_reset();
      rst = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      n_cmp++;
      if ({out_valid, out_kind, out_final, out_private, out_inter, out_param_count, out_overflow} !== '0
          || out_params !== '0) begin
         n_fail++;
         $display("FAIL reset_outputs: valid=%b kind=%0d final=%h priv=%h inter=%h cnt=%0d ovf=%b required all 0",
                  out_valid, out_kind, out_final, out_private, out_inter, out_param_count, out_overflow);
      end
      rst = 1'b1;
      @(posedge clk); #1;
      n_cmp++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_release: in_ready=%b out_valid=%b required 1/0", in_ready, out_valid);
      end
      q.delete();
   endtask

   task automatic test_csi_basic();
      rec_t r, e; bit ok;
      send(8'h1B); send_str("[12;40H");
      e = mk(2'd3, 8'h48, 8'h00, 8'h00, 2, 1'b0);
      e.prm[0 +: PW] = 16'd12; e.prm[PW +: PW] = 16'd40;
      pop_rec(r, ok); n_cmp++;
      if (!ok || r !== e) begin n_fail++; $display("FAIL csi_basic: got %s want %s", fmt(r), fmt(e)); end
   endtask

   task automatic test_private_esc();
      rec_t r, e; bit ok;
      send(8'h1B); send_str("[?25l");
      e = mk(2'd3, 8'h6C, 8'h3F, 8'h00, 1, 1'b0);
      e.prm[0 +: PW] = 16'd25;
      pop_rec(r, ok); n_cmp++;
      if (!ok || r !== e) begin n_fail++; $display("FAIL csi_private: got %s want %s", fmt(r), fmt(e)); end
      send(8'h1B); send_str("(B");
      e = mk(2'd2, 8'h42, 8'h00, 8'h28, 0, 1'b0);
      pop_rec(r, ok); n_cmp++;
      if (!ok || r !== e) begin n_fail++; $display("FAIL esc_inter: got %s want %s", fmt(r), fmt(e)); end
   endtask

   task automatic test_empty_fields();
      rec_t r, e; bit ok;
      send(8'h1B); send_str("[;5m");
      e = mk(2'd3, 8'h6D, 8'h00, 8'h00, 2, 1'b0);
      e.prm[PW +: PW] = 16'd5;
      pop_rec(r, ok); n_cmp++;
      if (!ok || r !== e) begin n_fail++; $display("FAIL empty_first: got %s want %s", fmt(r), fmt(e)); end
      send(8'h1B); send_str("[m");
      e = mk(2'd3, 8'h6D, 8'h00, 8'h00, 0, 1'b0);
      pop_rec(r, ok); n_cmp++;
      if (!ok || r !== e) begin n_fail++; $display("FAIL no_params: got %s want %s", fmt(r), fmt(e)); end
   endtask

   task automatic test_saturation_overflow();
      rec_t r, e; bit ok;
      send(8'h1B); send_str("[123456789m");
      e = mk(2'd3, 8'h6D, 8'h00, 8'h00, 1, 1'b0);
      e.prm[0 +: PW] = 16'hFFFF;
      pop_rec(r, ok); n_cmp++;
      if (!ok || r !== e) begin n_fail++; $display("FAIL saturate: got %s want %s", fmt(r), fmt(e)); end
      send(8'h1B); send(8'h5B);
      for (int i = 0; i < MP + 2; i++) begin
         send(8'h31);
         if (i != MP + 1) send(8'h3B);
      end
      send(8'h6D);
      e = mk(2'd3, 8'h6D, 8'h00, 8'h00, MP, 1'b1);
      for (int i = 0; i < MP; i++) e.prm[i*PW +: PW] = 16'd1;
      pop_rec(r, ok); n_cmp++;
      if (!ok || r !== e) begin n_fail++; $display("FAIL overflow: got %s want %s", fmt(r), fmt(e)); end
   endtask

   task automatic test_c0_cancel();
      rec_t r, e; bit ok;
      send(8'h1B); send_str("[3"); send(8'h0A); send_str("1A");
      e = mk(2'd1, 8'h0A, 8'h00, 8'h00, 0, 1'b0);
      pop_rec(r, ok); n_cmp++;
      if (!ok || r !== e) begin n_fail++; $display("FAIL exec_in_csi: got %s want %s", fmt(r), fmt(e)); end
      e = mk(2'd3, 8'h41, 8'h00, 8'h00, 1, 1'b0);
      e.prm[0 +: PW] = 16'd31;
      pop_rec(r, ok); n_cmp++;
      if (!ok || r !== e) begin n_fail++; $display("FAIL csi_after_exec: got %s want %s", fmt(r), fmt(e)); end
      send(8'h1B); send_str("[5"); send(8'h18); send(8'h41);
      e = mk(2'd0, 8'h41, 8'h00, 8'h00, 0, 1'b0);
      pop_rec(r, ok); n_cmp++;
      if (!ok || r !== e) begin n_fail++; $display("FAIL can_abort: got %s want %s", fmt(r), fmt(e)); end
   endtask

   task automatic test_back_to_back();
      rec_t r, e; bit ok;
      logic [7:0] bytes [4];
      bytes[0] = 8'h68; bytes[1] = 8'h69; bytes[2] = 8'h7F; bytes[3] = 8'hC3;
      for (int i = 0; i < 4; i++) send(bytes[i]);
      for (int i = 0; i < 4; i++) begin
         e = mk(2'd0, bytes[i], 8'h00, 8'h00, 0, 1'b0);
         pop_rec(r, ok); n_cmp++;
         if (!ok || r !== e) begin n_fail++; $display("FAIL print_%0d: got %s want %s", i, fmt(r), fmt(e)); end
      end
      send(8'h1B); send_str("[1"); send(8'h7F); send_str("2m");
      e = mk(2'd3, 8'h6D, 8'h00, 8'h00, 1, 1'b0);
      e.prm[0 +: PW] = 16'd12;
      pop_rec(r, ok); n_cmp++;
      if (!ok || r !== e) begin n_fail++; $display("FAIL del_in_csi: got %s want %s", fmt(r), fmt(e)); end
   endtask

   task automatic test_backpressure();
      rec_t r, e; bit ok;
      out_ready = 1'b0;
      send(8'h41);
      for (int i = 0; i < 5; i++) begin
         n_cmp++;
         if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_kind !== 2'd0 || out_final !== 8'h41) begin
            n_fail++;
            $display("FAIL hold_%0d: valid=%b in_ready=%b kind=%0d final=%h required 1/0/0/41",
                     i, out_valid, in_ready, out_kind, out_final);
         end
         @(posedge clk); #1;
      end
      out_ready = 1'b1;
      e = mk(2'd0, 8'h41, 8'h00, 8'h00, 0, 1'b0);
      pop_rec(r, ok); n_cmp++;
      if (!ok || r !== e) begin n_fail++; $display("FAIL release: got %s want %s", fmt(r), fmt(e)); end
   endtask

   task automatic test_reset_mid();
      rec_t r, e; bit ok;
      send(8'h1B); send_str("[7");
      in_data = 8'h58; in_valid = 1'b1; rst = 1'b0;
      @(posedge clk); #1;
      in_valid = 1'b0; rst = 1'b1;
      @(posedge clk); #1;
      n_cmp++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1 || q.size() != 0) begin
         n_fail++;
         $display("FAIL mid_reset: out_valid=%b in_ready=%b queued=%0d required 0/1/0", out_valid, in_ready, q.size());
      end
      send(8'h42);
      e = mk(2'd0, 8'h42, 8'h00, 8'h00, 0, 1'b0);
      pop_rec(r, ok); n_cmp++;
      if (!ok || r !== e) begin n_fail++; $display("FAIL after_reset: got %s want %s", fmt(r), fmt(e)); end
   endtask

   initial begin
      test_reset();
      test_csi_basic();
      test_private_esc();
      test_empty_fields();
      test_saturation_overflow();
      test_c0_cancel();
      test_back_to_back();
      test_backpressure();
      test_reset_mid();
      repeat (3) @(posedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
